weight_bram_reader: RTL

//  Upstream stage of the MAC-array controller. Fetches weight words from a

---
 rtl/weight_bram_reader_if.sv | 33 +++
 rtl/weight_bram_reader.sv | 106 ++++++++++
 2 files changed

// File: rtl/weight_bram_reader_if.sv
// Controller and BRAM signals of the weight reader. The slave side is the reader itself.
// The master side is the load-weight FSM together with the weight BRAM.
interface weight_bram_reader_if #(
  parameter int AW = 12,
  parameter int DW = 1280
);
  logic            address_reset;
  logic            read_en;
  logic            read_len;
  logic [AW-1:0]   end_addr;
  logic            bram_en_a;
  logic            bram_en_b;
  logic [AW-1:0]   bram_addr_a;
  logic [AW-1:0]   bram_addr_b;
  logic [DW-1:0]   bram_dout_a;
  logic [DW-1:0]   bram_dout_b;
  logic [2*DW-1:0] weight_out;
  logic            data_valid;
  logic            load_weight_finish;
  logic            read_err;

  modport slave (
    input  address_reset, read_en, read_len, end_addr, bram_dout_a, bram_dout_b,
    output bram_en_a, bram_en_b, bram_addr_a, bram_addr_b,
    output weight_out, data_valid, load_weight_finish, read_err
  );

  modport master (
    output address_reset, read_en, read_len, end_addr, bram_dout_a, bram_dout_b,
    input  bram_en_a, bram_en_b, bram_addr_a, bram_addr_b,
    input  weight_out, data_valid, load_weight_finish, read_err
  );
endinterface

// File: rtl/weight_bram_reader.sv
// Prefetches one or two weight words per address from a dual-port BRAM.
// Holds {B,A} with data_valid until read_en. Trigger to data_valid takes 2+BRAM_LATENCY cycles.
module weight_bram_reader #(
  parameter int BRAM_ADDRESS_WIDTH = 12,
  parameter int DATA_WIDTH         = 1280,
  parameter int BRAM_LATENCY       = 2
) (
  input  logic                clk,
  input  logic                rst,
  weight_bram_reader_if.slave bus
);
  localparam int AW = BRAM_ADDRESS_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(BRAM_LATENCY + 1);
  localparam logic [CW-1:0] LAT_C = CW'(BRAM_LATENCY);

  typedef enum logic [1:0] {IDLE, FETCH, READY, DONE} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   addr, addr_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [2*DW-1:0] wout, wout_nxt;
  logic            dv, dv_nxt;
  logic            err, err_nxt;
  logic [AW:0]     addr_b_ext;
  logic [AW:0]     addr_adv;
  logic            b_ok;

  // Extra top bit keeps the end_addr comparisons free of wrap.
  assign addr_b_ext = {1'b0, addr} + (AW+1)'(1);
  assign addr_adv   = {1'b0, addr} + (bus.read_len ? (AW+1)'(2) : (AW+1)'(1));
  assign b_ok       = (addr_b_ext <= {1'b0, bus.end_addr});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      addr  <= '0;
      cnt   <= '0;
      wout  <= '0;
      dv    <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      addr  <= addr_nxt;
      cnt   <= cnt_nxt;
      wout  <= wout_nxt;
      dv    <= dv_nxt;
      err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    cnt_nxt   = cnt;
    wout_nxt  = wout;
    dv_nxt    = dv;
    err_nxt   = err;

    if (bus.read_en && state != READY)
      err_nxt = 1'b1;

    if (bus.address_reset) begin
      state_nxt = FETCH;
      addr_nxt  = '0;
      cnt_nxt   = '0;
      dv_nxt    = 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (cnt == LAT_C) begin
            wout_nxt  = {(b_ok ? bus.bram_dout_b : {DW{1'b0}}), bus.bram_dout_a};
            dv_nxt    = 1'b1;
            state_nxt = READY;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        READY: begin
          if (bus.read_en) begin
            dv_nxt = 1'b0;
            if (addr_adv > {1'b0, bus.end_addr}) begin
              state_nxt = DONE;
            end else begin
              addr_nxt  = addr_adv[AW-1:0];
              state_nxt = FETCH;
              cnt_nxt   = '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Enables pulse only in the first FETCH cycle; addresses stay put for the whole fetch.
  assign bus.bram_en_a          = (state == FETCH) && (cnt == '0);
  assign bus.bram_en_b          = (state == FETCH) && (cnt == '0) && b_ok;
  assign bus.bram_addr_a        = (state == FETCH) ? addr : '0;
  assign bus.bram_addr_b        = (state == FETCH && b_ok) ? addr_b_ext[AW-1:0] : '0;
  assign bus.weight_out         = wout;
  assign bus.data_valid         = dv;
  assign bus.load_weight_finish = (state == DONE);
  assign bus.read_err           = err;
endmodule
